// File: rtl/tdcomp_race_sequencer.sv
// Race sequencer for the time-domain comparator: clears and fires the two
// delay lines, synchronizes the two race outputs, decides the winner and
// measures the inter-edge gap in clock cycles. The result is held on a
// valid/ready port until it is taken.

// One race branch: two metastability flops plus a history flop; a detection
// is a rising edge seen on the synchronized side.
module tdcomp_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic det
);
  localparam int STAGES = 3;

  // sync_pipe[0..1] are the synchronizer, sync_pipe[2] is the history bit
  logic [STAGES-1:0] sync_pipe;

  // shift the asynchronous branch output through the synchronizer chain
  always_ff @(posedge clk) begin
    if (rst) sync_pipe <= '0;
    else     sync_pipe <= {sync_pipe[STAGES-2:0], din};
  end

  assign det = sync_pipe[STAGES-2] & ~sync_pipe[STAGES-1];
endmodule

module tdcomp_race_sequencer #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 200,
  parameter int CLR_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_req,
  output logic             busy,
  output logic             cmp_rst,
  output logic             cmp_start,
  input  logic             edge_p,
  input  logic             edge_n,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_winner,
  output logic             res_tie,
  output logic             res_timeout,
  output logic [CNT_W-1:0] res_delta
);
  localparam int NUM_LANES = 2;
  localparam int LANE_P    = 0;
  localparam int LANE_N    = 1;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLR_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_FIRE, S_WAIT1, S_WAIT2, S_DONE
  } state_t;

  typedef struct packed {
    logic             winner;
    logic             tie;
    logic             timeout;
    logic [CNT_W-1:0] delta;
  } res_t;

  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  res_t res_q, res_nxt;

  logic [NUM_LANES-1:0] edge_in;
  logic [NUM_LANES-1:0] det;
  logic                 loser_det;

  assign edge_in = {edge_n, edge_p};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    tdcomp_edge_sync u_sync (
      .clk (clk),
      .rst (rst),
      .din (edge_in[g]),
      .det (det[g])
    );
  end

  // once a winner is latched only the other branch can end the race
  assign loser_det = res_q.winner ? det[LANE_N] : det[LANE_P];

  // state, cycle counter and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      res_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      res_q <= res_nxt;
    end
  end

  // next-state, counter/result updates and control outputs
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    res_nxt   = res_q;
    busy      = 1'b1;
    cmp_rst   = 1'b0;
    cmp_start = 1'b0;
    res_valid = 1'b0;
    case (state)
      S_IDLE: begin
        busy    = 1'b0;
        cnt_nxt = '0;
        if (start_req) state_nxt = S_CLR;
      end
      S_CLR: begin
        // the counter paces the clear pulse and leaves it at zero for firing
        cmp_rst = 1'b1;
        if (cnt == CLR_LAST) begin
          cnt_nxt   = '0;
          state_nxt = S_FIRE;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      S_FIRE: begin
        cmp_start = 1'b1;
        cnt_nxt   = '0;
        state_nxt = S_WAIT1;
      end
      S_WAIT1: begin
        cmp_start = 1'b1;
        cnt_nxt   = cnt + CNT_ONE;
        if (det[LANE_P] && det[LANE_N]) begin
          res_nxt.tie    = 1'b1;
          res_nxt.winner = 1'b0;
          res_nxt.delta  = '0;
          state_nxt      = S_DONE;
        end else if (det[LANE_P] || det[LANE_N]) begin
          // the winner's cycle counts as 0, so the next WAIT2 cycle is 1
          res_nxt.winner = det[LANE_P];
          cnt_nxt        = CNT_ONE;
          state_nxt      = S_WAIT2;
        end else if (cnt == TO_LAST) begin
          res_nxt.timeout = 1'b1;
          res_nxt.delta   = '0;
          state_nxt       = S_DONE;
        end
      end
      S_WAIT2: begin
        cmp_start = 1'b1;
        cnt_nxt   = cnt + CNT_ONE;
        if (loser_det) begin
          res_nxt.delta = cnt;
          state_nxt     = S_DONE;
        end else if (cnt == CNT_MAX) begin
          res_nxt.delta   = CNT_MAX;
          res_nxt.timeout = 1'b1;
          state_nxt       = S_DONE;
        end
      end
      S_DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          res_nxt   = '0;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign res_winner  = res_q.winner;
  assign res_tie     = res_q.tie;
  assign res_timeout = res_q.timeout;
  assign res_delta   = res_q.delta;
endmodule
